edge_event_arbiter: RTL
=======================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored input channels (2..16).
REQ-002 SHALL have parameter CH_W, default 2, width of channel index; SHALL equal ceil(log2(NUM_CH)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 sign_in  input  NUM_CH  monitored signals, one bit per channel, synchronous to clk.
REQ-006 edge_en_p  input  NUM_CH  per-channel enable for rising-edge events.
REQ-007 edge_en_n  input  NUM_CH  per-channel enable for falling-edge events.
REQ-008 evt_valid  output  1  output event slot holds a valid event.
REQ-009 evt_ready  input  1  consumer accepts event when evt_valid and evt_ready both high at a clock edge.
REQ-010 evt_ch  output  CH_W  channel index of the held event.
REQ-011 evt_pol  output  1  polarity of held event: 1 rising, 0 falling.
REQ-012 overflow  output  NUM_CH  sticky per-channel lost-event flag.
REQ-013 clr_ovf  input  1  synchronous clear of all overflow bits.

Function
REQ-014 Per channel, SHALL register sign_in into sign_q each cycle; rise = sign_in & ~sign_q, fall = ~sign_in & sign_q, evaluated combinationally in the sampling cycle.
REQ-015 SHALL keep pend_p[ch] / pend_n[ch]; set at clock edge when rise&edge_en_p / fall&edge_en_n.
REQ-016 Clearing an edge_en bit SHALL NOT clear an already-set pending bit.
REQ-017 Output slot is free when evt_valid=0 or (evt_valid&evt_ready); when free and any pending bit set, SHALL load one event into evt_ch/evt_pol, assert evt_valid, clear the granted pending bit, same edge.
REQ-018 When free and no pending bits set, evt_valid SHALL go 0 if the held event was accepted, else stay 0.
REQ-019 While evt_valid=1 and evt_ready=0, evt_valid/evt_ch/evt_pol SHALL hold stable.
REQ-020 Channel arbitration SHALL be round-robin: search starts at pointer ptr, ascending, wrapping NUM_CH-1 -> 0; after grant to channel k, ptr <= (k+1) mod NUM_CH; ptr unchanged when no grant.
REQ-021 Within a granted channel, rising SHALL win over falling when both pending; channel keeps its remaining pending bit for a later turn (ptr still advances).
REQ-022 Minimum latency: edge sampled at edge t, slot free at t+1 -> evt_valid=1 after edge t+1.
REQ-023 Throughput: one event per cycle with evt_ready held high.
REQ-024 Simultaneous grant-clear and new set on same pending bit: set SHALL win (bit stays 1).
REQ-025 Edge detected while its pending bit is 1 and not being granted that cycle: event SHALL be dropped and overflow[ch] set.
REQ-026 overflow bits SHALL be cleared by clr_ovf=1; new overflow in the same cycle as clr_ovf SHALL win.
REQ-027 evt_ch SHALL never exceed NUM_CH-1.

Reset
REQ-028 While rst_n=0 at a clock edge: sign_q=0, pend_p=0, pend_n=0, ptr=0, evt_valid=0, evt_ch=0, evt_pol=0, overflow=0.
REQ-029 Reset mid-operation SHALL discard held and pending events; no event output in the cycle after release unless a new edge was sampled.
REQ-030 sign_in=1 at reset release SHALL produce a rising event on that channel (sign_q resets to 0) if enabled.

Verification (NUM_CH=4, all enables 1 unless stated)
REQ-031 rst_n=0 two cycles, sign_in=4'b1111 -> evt_valid=0, overflow=4'b0000 throughout reset.
REQ-032 evt_ready=1, sign_in 4'b0000->4'b0100 at edge t -> after t+1 evt_valid=1, evt_ch=2, evt_pol=1, exactly one cycle; ptr=3.
REQ-033 evt_ready=1, ptr=0, sign_in 4'b0000->4'b1011 -> events ch0,ch1,ch3 (pol 1) on three consecutive cycles, then evt_valid=0, ptr=0.
REQ-034 evt_ready=0, ch1 rises then falls -> output holds ch1/pol1; raise evt_ready -> next cycle ch1/pol0 accepted, then evt_valid=0.
REQ-035 evt_ready=0, ch0 toggles 0->1->0->1->0 on consecutive cycles -> overflow=4'b0001 after second fall; clr_ovf=1 one cycle -> overflow=4'b0000.
REQ-036 edge_en_n[2]=0, ch2 falls -> no event; rst_n=0 while evt_valid=1 -> evt_valid=0 after the reset edge, pending cleared.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: detects rising/falling edges per channel,
// queues one pending event per polarity, emits them round-robin.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sign_in,
  input  logic [NUM_CH-1:0] edge_en_p,
  input  logic [NUM_CH-1:0] edge_en_n,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_pol,
  output logic [NUM_CH-1:0] overflow,
  input  logic              clr_ovf
);

  logic [NUM_CH-1:0] sign_q;
  logic [NUM_CH-1:0] pend_p;
  logic [NUM_CH-1:0] pend_n;
  logic [CH_W-1:0]   ptr;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] set_p;
  logic [NUM_CH-1:0] set_n;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] clr_p;
  logic [NUM_CH-1:0] clr_n;
  logic [NUM_CH-1:0] ovf_new;

  logic              slot_free;
  logic              gnt_vld;
  logic              fire;
  logic              gnt_pol;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   ptr_nxt;
  logic [CH_W:0]     scan;

  assign rise  = sign_in & ~sign_q;
  assign fall  = ~sign_in & sign_q;
  assign set_p = rise & edge_en_p;
  assign set_n = fall & edge_en_n;
  assign req   = pend_p | pend_n;

  assign slot_free = ~evt_valid | evt_ready;
  assign fire      = slot_free & gnt_vld;

  // round-robin search over pending channels starting at ptr
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    scan    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = {1'b0, ptr} + (CH_W+1)'(i);
      if (scan >= (CH_W+1)'(NUM_CH)) begin
        scan = scan - (CH_W+1)'(NUM_CH);
      end
      if (!gnt_vld && req[scan[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = scan[CH_W-1:0];
      end
    end
  end

  // one-hot of the selected channel, rising wins inside it
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = gnt_vld && (gnt_ch == CH_W'(i));
    end
  end

  assign gnt_pol = |(pend_p & sel_oh);
  assign clr_p   = fire ? (sel_oh & pend_p) : '0;
  assign clr_n   = fire ? (sel_oh & ~pend_p & pend_n) : '0;

  // an edge landing on a still-pending bit is lost
  assign ovf_new = (set_p & pend_p & ~clr_p)
                 | (set_n & pend_n & ~clr_n);

  assign ptr_nxt = (gnt_ch == CH_W'(NUM_CH-1))
                 ? '0 : gnt_ch + CH_W'(1);

  // edge history, pending flags and arbitration pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q <= '0;
      pend_p <= '0;
      pend_n <= '0;
      ptr    <= '0;
    end else begin
      sign_q <= sign_in;
      pend_p <= (pend_p & ~clr_p) | set_p;
      pend_n <= (pend_n & ~clr_n) | set_n;
      if (fire) begin
        ptr <= ptr_nxt;
      end
    end
  end

  // output slot: reload whenever empty or just accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_pol   <= 1'b0;
    end else if (slot_free) begin
      evt_valid <= gnt_vld;
      if (gnt_vld) begin
        evt_ch  <= gnt_ch;
        evt_pol <= gnt_pol;
      end
    end
  end

  // sticky lost-event flags, fresh losses beat the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= '0;
    end else begin
      overflow <= (clr_ovf ? '0 : overflow) | ovf_new;
    end
  end

endmodule
